dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares one single-port synchronous data memory (1-cycle read latency) between two requesters. The pipeline M stage is the primary requester; the display/debug scan port is the secondary one. Sits between the M stage, the seven-segment scanner and the data RAM. Gives the CPU priority, with a starvation guard for the debug port. Stalls the pipeline while the CPU waits for read data or is pre-empted.

Parameters:
AW, 10, word-address width
DW, 32, data width
STARVE_LIM, 8, cycles dbg_req may wait unserved before it pre-empts the CPU (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset
cpu_req  in  1  M-stage access request; held stable while cpu_stall=1
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  word address
cpu_wdata  in  DW  store data
cpu_rdata  out  DW  load data, valid when state CPU_RD
cpu_stall  out  1  freeze IF..M pipeline registers
dbg_req  in  1  level request from display scanner
dbg_addr  in  AW  sampled at debug grant
dbg_rdata  out  DW  registered debug read data
dbg_valid  out  1  one-cycle pulse, dbg_rdata updated
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid the cycle after a read enable
stall_cnt  out  32  CPU stall-cycle count (optional feature; 0 when the feature is compiled out)

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low. Both are fixed.
- On reset:
  - state=IDLE, starve counter=0.
  - All outputs are 0, including cpu_rdata, dbg_rdata, dbg_valid and stall_cnt.
  - Reset asserted mid-operation aborts the access. cpu_stall drops immediately.
- States:
  - IDLE: the grant decision is made here.
  - CPU_RD: CPU read data is returning.
  - DBG_RD: debug read data is returning.
- Grant in IDLE, combinational, evaluated in priority order:
  1. dbg_req=1 and starve counter==STARVE_LIM → debug grant.
  2. Else cpu_req=1 → CPU grant.
  3. Else dbg_req=1 → debug grant.
  4. Else idle: mem_en=0.
- CPU write grant (cycle G):
  - mem_en=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - cpu_stall=0. State stays IDLE.
  - Back-to-back writes run at one per cycle.
- CPU read grant:
  - Cycle G: mem_en=1, mem_we=0, cpu_stall=1. Next state CPU_RD.
  - G+1 (CPU_RD): cpu_rdata=mem_rdata, cpu_stall=0. Next state IDLE.
  - cpu_rdata is 0 in every other state.
  - Load latency is 2 cycles; each load costs 1 stall cycle.
- Debug grant:
  - Cycle G: mem_en=1, mem_we=0, mem_addr=dbg_addr. cpu_stall=cpu_req. Next state DBG_RD.
  - G+1 (DBG_RD): cpu_stall=cpu_req. dbg_rdata<=mem_rdata at end of cycle. Next state IDLE.
  - G+2: dbg_valid=1 for one cycle.
- Starve counter:
  - Increments each cycle dbg_req=1 and no debug grant. Saturates at STARVE_LIM.
  - Cleared on debug grant or when dbg_req=0.
- Simultaneous cpu_req and dbg_req below the limit: the CPU wins.
- A new cpu_req arriving in CPU_RD or DBG_RD waits; cpu_stall=1 if cpu_req is asserted.
- dbg_req dropped after a grant: the access still completes and dbg_valid still pulses.
- mem_* outputs are 0 when mem_en=0.

Optional Feature:
Macro DMEM_ARB_STATS_EN.
- Defined: stall_cnt increments (saturating at 0xFFFFFFFF) every cycle cpu_stall=1. Cleared by reset only.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding: IDLE=2'd0, CPU_RD=2'd1, DBG_RD=2'd2
  - default AW/DW
  - starve counter width of 8
- One sub-module: arb_starve_cnt (the saturating starvation counter with clear). Its inputs are inc, clr and lim; its output is hit.

Test Plan:
1. Reset: hold rst_n=0 with cpu_req=1 → all outputs 0. Release → first grant on the next edge.
2. CPU write: cpu_req=1, cpu_we=1, addr=0x010, wdata=0xDEADBEEF → same cycle mem_en=1, mem_we=1, mem_addr=0x010, cpu_stall=0. Issue 4 consecutive writes → 4 RAM writes in 4 cycles, no stall.
3. CPU read: addr 0x010 preloaded with 0xDEADBEEF → cycle G cpu_stall=1; G+1 cpu_stall=0, cpu_rdata=0xDEADBEEF; state back to IDLE.
4. Debug only: dbg_req=1, dbg_addr=0x005 holding 0x12345678 → mem_en at G; dbg_valid=1 and dbg_rdata=0x12345678 at G+2.
5. Starvation (STARVE_LIM=8): continuous CPU writes with dbg_req held from cycle 0 → cycles 0-7 CPU granted; cycle 8 debug granted with cpu_stall=1 in cycles 8-9; CPU resumes at cycle 10; counter restarts at 0.
6. Reset mid CPU_RD: drop rst_n during G+1 → cpu_stall=0 and cpu_rdata=0 immediately. After release, state=IDLE with no spurious dbg_valid. With DMEM_ARB_STATS_EN defined: stall_cnt=0 after reset and equals 1 after one subsequent load.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DBG_RD = 2'd2
  } state_t;

  localparam int DEF_AW   = 10;
  localparam int DEF_DW   = 32;
  localparam int STARVE_W = 8;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating wait counter for the debug requester
module arb_starve_cnt
  import dmem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  input  logic [STARVE_W-1:0] lim,
  output logic                hit
);

  logic [STARVE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != lim)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == lim);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter for a single-port 1-cycle-latency data RAM
// Optional stall statistics counter built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_LIM = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   stall_cnt
);

  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

  state_t        state, state_nxt;
  logic          dbg_grant;
  logic          starve_hit;
  logic          stall_c, en_c, we_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c, rdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dbg_grant = 1'b0;
    stall_c   = 1'b0;
    en_c      = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    rdata_c   = '0;
    case (state)
      IDLE: begin
        if (dbg_req && starve_hit) begin
          dbg_grant = 1'b1;
        end else if (cpu_req) begin
          en_c   = 1'b1;
          we_c   = cpu_we;
          addr_c = cpu_addr;
          if (cpu_we) begin
            wdata_c = cpu_wdata;
          end else begin
            stall_c   = 1'b1;
            state_nxt = CPU_RD;
          end
        end else if (dbg_req) begin
          dbg_grant = 1'b1;
        end
        if (dbg_grant) begin
          en_c      = 1'b1;
          addr_c    = dbg_addr;
          stall_c   = cpu_req;
          state_nxt = DBG_RD;
        end
      end
      CPU_RD: begin
        rdata_c   = mem_rdata;
        state_nxt = IDLE;
      end
      DBG_RD: begin
        stall_c   = cpu_req;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset must silence the combinational outputs too, not just the state.
  assign cpu_stall = rst_n & stall_c;
  assign mem_en    = rst_n & en_c;
  assign mem_we    = rst_n & we_c;
  assign mem_addr  = rst_n ? addr_c  : '0;
  assign mem_wdata = rst_n ? wdata_c : '0;
  assign cpu_rdata = rst_n ? rdata_c : '0;

  arb_starve_cnt u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dbg_req & ~dbg_grant),
    .clr   (~dbg_req | dbg_grant),
    .lim   (LIM),
    .hit   (starve_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata <= '0;
      dbg_valid <= 1'b0;
    end else begin
      dbg_valid <= (state == DBG_RD);
      if (state == DBG_RD) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cpu_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata, stall_cnt;
  logic        cpu_stall, dbg_req, dbg_valid, mem_en, mem_we;
  logic [31:0] ram [0:1023];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(10), .DW(32), .STARVE_LIM(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h000; cpu_wdata = '0;
    dbg_req = 1'b1; dbg_addr = 10'h000;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", cpu_stall); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
    n_cmp++; if ({cpu_rdata, dbg_rdata, stall_cnt} !== 96'd0) begin n_bad++; $display("FAIL rst_data got %h want 0", {cpu_rdata, dbg_rdata, stall_cnt}); end
    n_cmp++; if (dbg_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dbg_valid got %b want 0", dbg_valid); end
    dbg_req = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we, cpu_stall} !== 3'b101) begin n_bad++; $display("FAIL rst_first_grant got %b want 101", {mem_en, mem_we, cpu_stall}); end
    tick();
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_first_rd_stall got %b want 0", cpu_stall); end
    cpu_req = 1'b0;
  endtask

  task automatic test_cpu_write;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h010; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we, cpu_stall} !== 3'b110) begin n_bad++; $display("FAIL wr_ctl got %b want 110", {mem_en, mem_we, cpu_stall}); end
    n_cmp++; if (mem_addr !== 10'h010 || mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_bus got %h/%h want 010/deadbeef", mem_addr, mem_wdata); end
    for (int i = 1; i < 4; i++) begin
      tick();
      cpu_addr = 10'h010 + 10'(i); cpu_wdata = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      n_cmp++; if ({mem_en, mem_we, cpu_stall} !== 3'b110 || mem_addr !== 10'h010 + 10'(i)) begin
        n_bad++; $display("FAIL wr_b2b%0d got %b addr %h want 110 addr %h", i, {mem_en, mem_we, cpu_stall}, mem_addr, 10'h010 + 10'(i));
      end
    end
    tick();
    cpu_req = 1'b0;
    n_cmp++; if (ram[10'h013] !== 32'hA000_0003) begin n_bad++; $display("FAIL wr_ram got %h want a0000003", ram[10'h013]); end
  endtask

  task automatic test_cpu_read;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we, cpu_stall} !== 3'b101) begin n_bad++; $display("FAIL rd_g got %b want 101", {mem_en, mem_we, cpu_stall}); end
    tick();
    @(negedge clk);
    n_cmp++; if (cpu_stall !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL rd_g1_ctl got %b%b want 00", cpu_stall, mem_en); end
    n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data got %h want deadbeef", cpu_rdata); end
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (cpu_rdata !== 32'd0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL rd_idle got %h/%b want 0/0", cpu_rdata, mem_en); end
  endtask

  task automatic test_debug;
    ram[10'h005] = 32'h12345678;
    tick();
    dbg_req = 1'b1; dbg_addr = 10'h005;
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we, cpu_stall} !== 3'b100 || mem_addr !== 10'h005) begin n_bad++; $display("FAIL dbg_g got %b addr %h want 100 addr 005", {mem_en, mem_we, cpu_stall}, mem_addr); end
    tick();
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h030; cpu_wdata = 32'h0000_0030;
    @(negedge clk);
    n_cmp++; if ({mem_en, cpu_stall, dbg_valid} !== 3'b010) begin n_bad++; $display("FAIL dbg_wait got %b want 010", {mem_en, cpu_stall, dbg_valid}); end
    tick();
    @(negedge clk);
    n_cmp++; if (dbg_valid !== 1'b1 || dbg_rdata !== 32'h12345678) begin n_bad++; $display("FAIL dbg_data got %b/%h want 1/12345678", dbg_valid, dbg_rdata); end
    n_cmp++; if ({mem_en, mem_we, cpu_stall} !== 3'b110) begin n_bad++; $display("FAIL dbg_cpu_resume got %b want 110", {mem_en, mem_we, cpu_stall}); end
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_valid !== 1'b0) begin n_bad++; $display("FAIL dbg_pulse got %b want 0", dbg_valid); end
  endtask

  task automatic test_starvation;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; dbg_req = 1'b1; dbg_addr = 10'h005;
    for (int i = 0; i < 8; i++) begin
      cpu_addr = 10'h020 + 10'(i); cpu_wdata = 32'(i);
      @(negedge clk);
      n_cmp++; if ({mem_en, mem_we, cpu_stall} !== 3'b110) begin n_bad++; $display("FAIL starve_cpu%0d got %b want 110", i, {mem_en, mem_we, cpu_stall}); end
      tick();
    end
    cpu_addr = 10'h028;
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we, cpu_stall} !== 3'b101 || mem_addr !== 10'h005) begin n_bad++; $display("FAIL starve_dbg got %b addr %h want 101 addr 005", {mem_en, mem_we, cpu_stall}, mem_addr); end
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_en, cpu_stall} !== 2'b01) begin n_bad++; $display("FAIL starve_g1 got %b want 01", {mem_en, cpu_stall}); end
    tick();
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we, cpu_stall, dbg_valid} !== 4'b1101 || mem_addr !== 10'h028) begin
      n_bad++; $display("FAIL starve_resume got %b addr %h want 1101 addr 028", {mem_en, mem_we, cpu_stall, dbg_valid}, mem_addr);
    end
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    @(negedge clk);
    n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rmid_g got %b want 1", cpu_stall); end
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'd0) begin n_bad++; $display("FAIL rmid_abort got %b/%h want 0/0", cpu_stall, cpu_rdata); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rmid_cnt got %0d want 0", stall_cnt); end
    cpu_req = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_en, dbg_valid, cpu_stall} !== 3'b000) begin n_bad++; $display("FAIL rmid_idle got %b want 000", {mem_en, dbg_valid, cpu_stall}); end
    tick();
    cpu_req = 1'b1;
    tick();
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_dbg got %b want 0", dbg_valid); end
`ifdef DMEM_ARB_STATS_EN
    n_cmp++; if (stall_cnt !== 32'd1) begin n_bad++; $display("FAIL stats_one_load got %0d want 1", stall_cnt); end
`else
    n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL stats_off got %0d want 0", stall_cnt); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_debug();
    test_starvation();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
